// File: rtl/sirc_rx_ctrl_pkg.sv
// Sony SIRC-12 receiver shared types: FSM states, tick widths,
// classification windows and small counter helpers.
package sirc_pkg;

  localparam int NBITS       = 12;
  localparam int CNT_W       = 6;
  localparam int START_TICKS = 32;
  localparam int ONE_TICKS   = 16;
  localparam int ZERO_TICKS  = 8;
  localparam int TOL         = 3;
  localparam int SPACE_MIN   = 3;
  localparam int SPACE_MAX   = 16;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [3:0]       idx_t;

  localparam cnt_t START_LO = cnt_t'(START_TICKS - TOL);
  localparam cnt_t START_HI = cnt_t'(START_TICKS + TOL);
  localparam cnt_t ONE_LO   = cnt_t'(ONE_TICKS - TOL);
  localparam cnt_t ONE_HI   = cnt_t'(ONE_TICKS + TOL);
  localparam cnt_t ZERO_LO  = cnt_t'(ZERO_TICKS - TOL);
  localparam cnt_t ZERO_HI  = cnt_t'(ZERO_TICKS + TOL);
  localparam cnt_t SPC_LO   = cnt_t'(SPACE_MIN);
  localparam cnt_t SPC_HI   = cnt_t'(SPACE_MAX);
  // a data mark longer than the longest start mark can never classify
  localparam cnt_t MARK_HI  = START_HI;
  localparam idx_t LAST_IDX = idx_t'(NBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_MK,
    S_SPACE,
    S_BIT_MK,
    S_DONE
  } state_t;

  function automatic logic in_range(cnt_t v, cnt_t lo, cnt_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic cnt_t sat_inc(cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/sirc_rx_ctrl_ir_sync.sv
// Two-flop synchroniser for the raw IR pin plus polarity fix.
// Ports: clk, reset, ir_i (async pin) -> mark_o (1 = carrier present).
module sirc_rx_ctrl_ir_sync #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic ir_i,
  output logic mark_o
);

  logic [1:0] sync_q;

  // reset to the idle (no carrier) pin level
  always_ff @(posedge clk) begin
    if (reset) sync_q <= {2{ACTIVE_LOW}};
    else       sync_q <= {sync_q[0], ir_i};
  end

  assign mark_o = sync_q[1] ^ ACTIVE_LOW;

endmodule

// File: rtl/sirc_rx_ctrl.sv
// SIRC-12 frame decoder: times marks/spaces in sample ticks, shifts bits LSB first.
// Ports: clk, reset, sample_en, ir_in -> data/command/address, valid, error, busy.
module sirc_rx_ctrl
  import sirc_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic             ir_in,
  output logic [NBITS-1:0] data,
  output logic [6:0]       command,
  output logic [4:0]       address,
  output logic             valid,
  output logic             error,
  output logic             busy
);

  logic mark;

  sirc_rx_ctrl_ir_sync #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .ir_i  (ir_in),
    .mark_o(mark)
  );

  state_t           state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  idx_t             idx_q, idx_d;
  logic [NBITS-1:0] sreg_q, sreg_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             busy_q, busy_d;

  cnt_t inc;
  logic zero_ok;
  logic one_ok;

  assign inc     = sat_inc(cnt_q);
  assign zero_ok = in_range(cnt_q, ZERO_LO, ZERO_HI);
  assign one_ok  = in_range(cnt_q, ONE_LO, ONE_HI);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sreg_d  = sreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    // DONE publishes on the very next clock, tick or not
    if (state_q == S_DONE) begin
      data_d  = sreg_q;
      valid_d = 1'b1;
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (sample_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (mark) begin
            state_d = S_START_MK;
            cnt_d   = cnt_t'(1);
          end
        end
        S_START_MK: begin
          if (mark) begin
            cnt_d = inc;
          end else if (in_range(cnt_q, START_LO, START_HI)) begin
            state_d = S_SPACE;
            cnt_d   = cnt_t'(1);
            idx_d   = '0;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_SPACE: begin
          if (!mark) begin
            if (inc > SPC_HI) begin
              error_d = 1'b1;
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = inc;
            end
          end else if (cnt_q < SPC_LO) begin
            error_d = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = S_BIT_MK;
            cnt_d   = cnt_t'(1);
          end
        end
        S_BIT_MK: begin
          if (mark) begin
            if (inc > MARK_HI) begin
              error_d = 1'b1;
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = inc;
            end
          end else if (!(zero_ok || one_ok)) begin
            error_d = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            sreg_d[idx_q] = one_ok;
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
              cnt_d   = '0;
            end else begin
              idx_d   = idx_q + idx_t'(1);
              state_d = S_SPACE;
              cnt_d   = cnt_t'(1);
            end
          end
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sreg_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sreg_q  <= sreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      error_q <= error_d;
      busy_q  <= busy_d;
    end
  end

  assign data    = data_q;
  assign command = data_q[6:0];
  assign address = data_q[11:7];
  assign valid   = valid_q;
  assign error   = error_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sirc_rx_ctrl.sv
// Self-checking bench for sirc_rx_ctrl: frames described as mark/space
// run lengths in ticks, outcome predicted from those lengths.
module tb_sirc_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_en = 1'b0;
  logic        ir_in = 1'b1;
  logic [11:0] data;
  logic [6:0]  command;
  logic [4:0]  address;
  logic        valid;
  logic        error;
  logic        busy;

  always #5 clk = ~clk;

  sirc_rx_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .sample_en(sample_en),
    .ir_in    (ir_in),
    .data     (data),
    .command  (command),
    .address  (address),
    .valid    (valid),
    .error    (error),
    .busy     (busy)
  );

  typedef struct {
    int          st;
    int          et;
    bit          err;
    logic [11:0] d;
  } frame_t;

  int          errors = 0;
  int          checks = 0;
  frame_t      fq[$];
  int          segs[$];
  int          drv_tk = 0;
  int          ctk = 0;
  int          nvalid = 0;
  int          nerror = 0;
  logic [11:0] last_good = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Outcome of a frame from its run lengths: which tick ends it,
  // whether it errors, the decoded word and how many segments to drive.
  function automatic void predict(input int base, output frame_t f,
                                  output int nseg);
    int t;
    int s;
    int m;
    f.st  = base;
    f.err = 1'b1;
    f.d   = '0;
    t     = base;
    nseg  = 1;
    if (segs[0] < 29 || segs[0] > 35) begin
      f.et = t + segs[0];
      return;
    end
    t += segs[0];
    for (int i = 0; i < 12; i++) begin
      s = segs[1+2*i];
      m = segs[2+2*i];
      nseg = 2 + 2 * i;
      if (s > 16) begin
        f.et = t + 16;
        return;
      end
      nseg = 3 + 2 * i;
      if (s < 3) begin
        f.et = t + s;
        return;
      end
      t += s;
      if (m > 35) begin
        f.et = t + 35;
        return;
      end
      if (m >= 5 && m <= 11) f.d[i] = 1'b0;
      else if (m >= 13 && m <= 19) f.d[i] = 1'b1;
      else begin
        f.et = t + m;
        return;
      end
      t += m;
    end
    f.err = 1'b0;
    f.et  = t;
  endfunction

  // compare process: every clock, outputs against the queued predictions
  initial begin
    bit     rst_s;
    bit     tick;
    bit     done_next;
    bit     ev_err;
    bit     ev_val;
    bit     exp_busy;
    frame_t f;
    done_next = 1'b0;
    forever begin
      @(posedge clk);
      rst_s = reset;
      tick  = sample_en && !reset;
      #1;
      ev_err   = 1'b0;
      ev_val   = 1'b0;
      exp_busy = 1'b0;
      if (rst_s) begin
        fq.delete();
        last_good = '0;
        done_next = 1'b0;
      end else begin
        if (tick) ctk++;
        if (done_next) begin
          ev_val    = 1'b1;
          last_good = fq[0].d;
          void'(fq.pop_front());
          done_next = 1'b0;
        end else if (fq.size() > 0) begin
          f = fq[0];
          if (tick && ctk == f.et) begin
            if (f.err) begin
              ev_err = 1'b1;
              void'(fq.pop_front());
            end else begin
              done_next = 1'b1;
              exp_busy  = 1'b1;
            end
          end else begin
            exp_busy = (ctk >= f.st);
          end
        end
      end
      chk("valid", valid, ev_val);
      chk("error", error, ev_err);
      chk("busy", busy, exp_busy);
      chk("data", data, last_good);
      chk("command", command, last_good[6:0]);
      chk("address", address, last_good[11:7]);
      if (valid) nvalid++;
      if (error) nerror++;
    end
  end

  task automatic do_tick(input bit m);
    int p;
    p = $urandom_range(3, 5);
    ir_in = ~m;
    repeat (p - 1) @(negedge clk);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    drv_tk++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b0);
  endtask

  task automatic drive_segs(input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < segs[i]; j++) do_tick((i % 2) == 0);
  endtask

  task automatic gen_frame(input logic [11:0] d, input bit rnd);
    segs.delete();
    segs.push_back(rnd ? int'($urandom_range(29, 35)) : 32);
    for (int i = 0; i < 12; i++) begin
      segs.push_back(rnd ? int'($urandom_range(3, 16)) : 8);
      if (d[i]) segs.push_back(rnd ? int'($urandom_range(13, 19)) : 16);
      else      segs.push_back(rnd ? int'($urandom_range(5, 11)) : 8);
    end
  endtask

  task automatic run_frame(input int gap, output frame_t f,
                           output int base);
    int n;
    base = drv_tk + 1;
    predict(base, f, n);
    fq.push_back(f);
    drive_segs(n);
    idle(gap);
  endtask

  initial begin
    frame_t      f;
    int          base;
    int          v0;
    int          e0;
    int          k;
    int          bi;
    logic [11:0] rd;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(4);

    // 1: nominal frame cmd 0x15 addr 0x01
    v0 = nvalid;
    gen_frame(12'h095, 1'b0);
    run_frame(3, f, base);
    chk("t1_model_data", f.d, 12'h095);
    chk("t1_model_et", f.et - base, 256);
    chk("t1_data", data, 12'h095);
    chk("t1_cmd", command, 7'h15);
    chk("t1_addr", address, 5'h01);
    chk("t1_nvalid", nvalid - v0, 1);

    // 2: range edges accepted
    gen_frame(12'h0F0, 1'b0);
    segs[0] = 29; segs[2] = 5; segs[4] = 11; segs[10] = 13; segs[12] = 19;
    run_frame(2, f, base);
    chk("t2_lo_data", data, 12'h0F0);
    gen_frame(12'h00F, 1'b0);
    segs[0] = 35; segs[2] = 19; segs[4] = 13; segs[10] = 5; segs[12] = 11;
    run_frame(2, f, base);
    chk("t2_hi_data", data, 12'h00F);
    // 2: just outside the windows
    e0 = nerror;
    gen_frame(12'hABC, 1'b0);
    segs[0] = 28;
    run_frame(2, f, base);
    gen_frame(12'hABC, 1'b0);
    segs[6] = 12;
    run_frame(2, f, base);
    gen_frame(12'hABC, 1'b0);
    segs[8] = 36;
    run_frame(2, f, base);
    chk("t2_nerror", nerror - e0, 3);
    chk("t2_data_held", data, 12'h00F);

    // 3: long space after bit 5, then clean 0xFFF
    e0 = nerror;
    gen_frame(12'h5A5, 1'b0);
    segs[13] = 17;
    run_frame(5, f, base);
    chk("t3_err", nerror - e0, 1);
    chk("t3_busy", busy, 1'b0);
    gen_frame(12'hFFF, 1'b0);
    run_frame(2, f, base);
    chk("t3_data", data, 12'hFFF);

    // 4: two-tick glitch, then single-clock glitch between ticks
    e0 = nerror;
    segs.delete();
    segs.push_back(2);
    run_frame(3, f, base);
    chk("t4_err", nerror - e0, 1);
    ir_in = 1'b1;
    @(negedge clk);
    ir_in = 1'b0;
    @(negedge clk);
    ir_in = 1'b1;
    repeat (3) @(negedge clk);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    drv_tk++;
    idle(2);
    chk("t4_glitch_busy", busy, 1'b0);
    chk("t4_glitch_err", nerror - e0, 1);

    // 5: reset after bit 7 mark
    v0 = nvalid;
    e0 = nerror;
    gen_frame(12'h3C3, 1'b0);
    base = drv_tk + 1;
    predict(base, f, k);
    fq.push_back(f);
    drive_segs(17);
    idle(2);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(3);
    chk("t5_data", data, 12'h000);
    chk("t5_busy", busy, 1'b0);
    chk("t5_noev", (nvalid - v0) + (nerror - e0), 0);
    gen_frame(12'h000, 1'b0);
    run_frame(2, f, base);
    chk("t5_nvalid", nvalid - v0, 1);

    // 6: two frames 45 ms apart
    v0 = nvalid;
    gen_frame(12'h012, 1'b0);
    run_frame(600, f, base);
    chk("t6_first", data, 12'h012);
    gen_frame(12'h013, 1'b0);
    run_frame(2, f, base);
    chk("t6_second", data, 12'h013);
    chk("t6_nvalid", nvalid - v0, 2);

    // random frames, some with one injected fault
    for (int r = 0; r < 14; r++) begin
      rd = 12'($urandom);
      gen_frame(rd, 1'b1);
      bi = $urandom_range(0, 11);
      k  = $urandom_range(0, 7);
      case (k)
        0: segs[0] = $urandom_range(20, 28);
        1: segs[2+2*bi] = ($urandom_range(0, 1) != 0) ? 12 :
                          int'($urandom_range(20, 30));
        2: segs[1+2*bi] = $urandom_range(17, 20);
        3: segs[2+2*bi] = 36;
        4: begin
          segs[1+2*bi] = $urandom_range(1, 2);
          segs[2+2*bi] = 1;
        end
        default: begin
        end
      endcase
      run_frame($urandom_range(1, 20), f, base);
    end

    idle(4);
    chk("drain", fq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
